// File: rtl/dac_pkg.sv
// Shared constants for the DAC sample path: mode encodings and default sample width.
package dac_pkg;

    localparam logic MODE_FIFO = 1'b0;
    localparam logic MODE_LOOP = 1'b1;

    localparam int SAMPLE_BITS = 8;

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port sample RAM: synchronous write, registered read gated by rd_en_i.
// The read register resets to zero; the array itself is zero only at configuration.
module sample_ram
    import dac_pkg::*;
#(
    parameter  int BITS  = SAMPLE_BITS,
    parameter  int DEPTH = 128,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en_i,
    input  logic [AW-1:0]   wr_addr_i,
    input  logic [BITS-1:0] wr_data_i,
    input  logic            rd_en_i,
    input  logic [AW-1:0]   rd_addr_i,
    output logic [BITS-1:0] rd_data_o
);

    logic [BITS-1:0] mem [DEPTH] = '{default: '0};
    logic [BITS-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    // Without a read enable the output register keeps the last sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sample_buffer.sv
// DAC sample store: pointers, level, sticky status and mode/flush control around sample_ram.
// FIFO mode consumes entries on read; LOOP mode replays stored entries endlessly.
module sample_buffer
    import dac_pkg::*;
#(
    parameter  int BITS  = SAMPLE_BITS,
    parameter  int DEPTH = 128,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic            clear,
    input  logic            wr_en,
    input  logic [BITS-1:0] wr_data,
    output logic            wr_ready,
    input  logic            rd_en,
    output logic [BITS-1:0] rd_data,
    output logic            rd_valid,
    output logic [AW:0]     level,
    output logic            empty,
    output logic            overflow,
    output logic            underflow
);

    localparam int          LW       = AW + 1;
    localparam logic [AW:0] FULL_LVL = LW'(DEPTH);

    logic          mode_q;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          rd_valid_q, rd_valid_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic          flush;
    logic          is_empty;
    logic          can_write;
    logic          wr_acc;
    logic          rd_acc;
    logic [AW:0]   level_m1;
    logic [AW-1:0] loop_last;

    // A mode change discards the buffer so stale samples never play in the new mode.
    assign flush     = clear || (mode != mode_q);
    assign is_empty  = (level_q == '0);
    assign can_write = (level_q != FULL_LVL);
    assign wr_acc    = !flush && wr_en && can_write;
    assign rd_acc    = !flush && rd_en && !is_empty;

    assign level_m1  = level_q - 1'b1;
    assign loop_last = level_m1[AW-1:0];

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            rd_valid_d = rd_acc;

            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end

            if (rd_acc) begin
                if (mode_q == MODE_LOOP && rd_ptr_q == loop_last) begin
                    rd_ptr_d = '0;
                end else begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
            end

            // LOOP playback never consumes, so only writes move the level there.
            if (wr_acc && !(rd_acc && mode_q == MODE_FIFO)) begin
                level_d = level_q + 1'b1;
            end else if (!wr_acc && rd_acc && mode_q == MODE_FIFO) begin
                level_d = level_q - 1'b1;
            end

            if (wr_en && !can_write) begin
                overflow_d = 1'b1;
            end
            if (rd_en && is_empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q      <= mode;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            mode_q      <= mode;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    sample_ram #(
        .BITS  (BITS),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_acc),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_data)
    );

    assign wr_ready  = can_write;
    assign rd_valid  = rd_valid_q;
    assign level     = level_q;
    assign empty     = is_empty;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_sample_buffer.sv
// Directed bench for sample_buffer at DEPTH=4: FIFO, fill/overflow, empty collisions,
// LOOP playback, mode-change flush, reset and clear.
module tb_sample_buffer;

    localparam int BITS  = 8;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic            clk;
    logic            rst_n;
    logic            mode;
    logic            clear;
    logic            wr_en;
    logic [BITS-1:0] wr_data;
    logic            wr_ready;
    logic            rd_en;
    logic [BITS-1:0] rd_data;
    logic            rd_valid;
    logic [AW:0]     level;
    logic            empty;
    logic            overflow;
    logic            underflow;

    int checks;
    int failures;

    sample_buffer #(
        .BITS  (BITS),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .clear     (clear),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .level     (level),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 ns after the edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = 1'b0; clear = 1'b0;
        wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
        tick();
        tick();
        checks++;
        if (level !== 3'd0 || empty !== 1'b1 || wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_status level=%0d empty=%b wr_ready=%b exp 0/1/1", level, empty, wr_ready);
        end
        checks++;
        if (rd_data !== 8'h00 || rd_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs rd_data=%h rd_valid=%b ovf=%b udf=%b exp 00/0/0/0",
                     rd_data, rd_valid, overflow, underflow);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fifo();
        for (int k = 1; k <= 3; k++) begin
            wr_en = 1'b1; wr_data = 8'(k);
            tick();
        end
        wr_en = 1'b0;
        checks++;
        if (level !== 3'd3 || empty !== 1'b0) begin
            failures++;
            $display("FAIL fifo_level_after_writes level=%0d empty=%b exp 3/0", level, empty);
        end
        for (int k = 1; k <= 3; k++) begin
            rd_en = 1'b1;
            tick();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== 8'(k)) begin
                failures++;
                $display("FAIL fifo_read%0d rd_valid=%b rd_data=%0d exp 1/%0d", k, rd_valid, rd_data, k);
            end
        end
        rd_en = 1'b0;
        tick();
        checks++;
        if (rd_valid !== 1'b0 || level !== 3'd0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL fifo_drained rd_valid=%b level=%0d empty=%b exp 0/0/1", rd_valid, level, empty);
        end
    endtask

    task automatic test_fill();
        for (int k = 0; k < 4; k++) begin
            wr_en = 1'b1; wr_data = 8'(10 + k);
            tick();
        end
        checks++;
        if (level !== 3'd4 || wr_ready !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL fill_full level=%0d wr_ready=%b ovf=%b exp 4/0/0", level, wr_ready, overflow);
        end
        wr_data = 8'h55;
        tick();
        checks++;
        if (overflow !== 1'b1 || level !== 3'd4) begin
            failures++;
            $display("FAIL fill_overflow ovf=%b level=%0d exp 1/4", overflow, level);
        end
        wr_data = 8'h66; rd_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        checks++;
        if (level !== 3'd3 || rd_data !== 8'd10 || rd_valid !== 1'b1) begin
            failures++;
            $display("FAIL full_wr_rd level=%0d rd_data=%0d rd_valid=%b exp 3/10/1", level, rd_data, rd_valid);
        end
        for (int k = 1; k < 4; k++) begin
            rd_en = 1'b1;
            tick();
            checks++;
            if (rd_data !== 8'(10 + k)) begin
                failures++;
                $display("FAIL fill_drain%0d rd_data=%0d exp %0d", k, rd_data, 10 + k);
            end
        end
        rd_en = 1'b0;
        checks++;
        if (empty !== 1'b1 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL fill_sticky empty=%b ovf=%b exp 1/1", empty, overflow);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (overflow !== 1'b0 || rd_data !== 8'd13) begin
            failures++;
            $display("FAIL clear_flags ovf=%b rd_data=%0d exp 0/13", overflow, rd_data);
        end
    endtask

    task automatic test_empty_wr_rd();
        wr_en = 1'b1; wr_data = 8'hAA; rd_en = 1'b1;
        tick();
        wr_en = 1'b0;
        checks++;
        if (underflow !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 8'd13 || level !== 3'd1) begin
            failures++;
            $display("FAIL empty_wr_rd udf=%b rd_valid=%b rd_data=%h level=%0d exp 1/0/0d/1",
                     underflow, rd_valid, rd_data, level);
        end
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'hAA || level !== 3'd0) begin
            failures++;
            $display("FAIL empty_then_read rd_valid=%b rd_data=%h level=%0d exp 1/aa/0", rd_valid, rd_data, level);
        end
    endtask

    task automatic test_loop();
        logic [BITS-1:0] seq[7] = '{8'd10, 8'd20, 8'd30, 8'd10, 8'd20, 8'd30, 8'd10};
        logic [BITS-1:0] tail[3] = '{8'd30, 8'd40, 8'd10};
        mode = 1'b1;
        tick();
        checks++;
        if (level !== 3'd0 || underflow !== 1'b0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL loop_entry_flush level=%0d udf=%b empty=%b exp 0/0/1", level, underflow, empty);
        end
        for (int k = 0; k < 3; k++) begin
            wr_en = 1'b1; wr_data = 8'(10 * (k + 1));
            tick();
        end
        wr_en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            rd_en = 1'b1;
            tick();
            checks++;
            if (rd_data !== seq[k] || rd_valid !== 1'b1) begin
                failures++;
                $display("FAIL loop_play%0d rd_data=%0d rd_valid=%b exp %0d/1", k, rd_data, rd_valid, seq[k]);
            end
        end
        checks++;
        if (level !== 3'd3) begin
            failures++;
            $display("FAIL loop_level level=%0d exp 3", level);
        end
        wr_en = 1'b1; wr_data = 8'd40;
        tick();
        wr_en = 1'b0;
        checks++;
        if (rd_data !== 8'd20 || level !== 3'd4) begin
            failures++;
            $display("FAIL loop_extend rd_data=%0d level=%0d exp 20/4", rd_data, level);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (rd_data !== tail[k]) begin
                failures++;
                $display("FAIL loop_extended%0d rd_data=%0d exp %0d", k, rd_data, tail[k]);
            end
        end
        rd_en = 1'b0;
        tick();
    endtask

    task automatic test_mode_toggle();
        mode = 1'b0;
        tick();
        for (int k = 5; k <= 7; k++) begin
            wr_en = 1'b1; wr_data = 8'(k);
            tick();
        end
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_data !== 8'd5 || level !== 3'd2) begin
            failures++;
            $display("FAIL toggle_setup rd_data=%0d level=%0d exp 5/2", rd_data, level);
        end
        mode = 1'b1; wr_en = 1'b1; wr_data = 8'd9; rd_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        checks++;
        if (level !== 3'd0 || empty !== 1'b1 || rd_data !== 8'd5 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL toggle_flush level=%0d empty=%b rd_data=%0d rd_valid=%b exp 0/1/5/0",
                     level, empty, rd_data, rd_valid);
        end
        checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            failures++;
            $display("FAIL toggle_flags ovf=%b udf=%b exp 0/0", overflow, underflow);
        end
        tick();
        checks++;
        if (level !== 3'd0) begin
            failures++;
            $display("FAIL toggle_ignored_write level=%0d exp 0", level);
        end
    endtask

    task automatic test_reset_and_clear();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (underflow !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_underflow udf=%b exp 1", underflow);
        end
        wr_en = 1'b1; wr_data = 8'd1;
        tick();
        wr_data = 8'd2;
        tick();
        rd_en = 1'b1;
        tick();
        rst_n = 1'b0; wr_data = 8'd3;
        tick();
        rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        checks++;
        if (level !== 3'd0 || empty !== 1'b1 || wr_ready !== 1'b1 || rd_data !== 8'h00 ||
            rd_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_burst level=%0d empty=%b wr_ready=%b rd_data=%h rd_valid=%b ovf=%b udf=%b exp 0/1/1/00/0/0/0",
                     level, empty, wr_ready, rd_data, rd_valid, overflow, underflow);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wr_en = 1'b1; wr_data = 8'(8'h77 + 8'(k * 17));
            tick();
        end
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_data !== 8'h77 || underflow !== 1'b1 || level !== 3'd2) begin
            failures++;
            $display("FAIL pre_clear rd_data=%h udf=%b level=%0d exp 77/1/2", rd_data, underflow, level);
        end
        clear = 1'b1; wr_en = 1'b1; wr_data = 8'hEE; rd_en = 1'b1;
        tick();
        clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        checks++;
        if (level !== 3'd0 || underflow !== 1'b0 || rd_data !== 8'h77 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL clear_flush level=%0d udf=%b rd_data=%h rd_valid=%b exp 0/0/77/0",
                     level, underflow, rd_data, rd_valid);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_fifo();
        test_fill();
        test_empty_wr_rd();
        test_loop();
        test_mode_toggle();
        test_reset_and_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
